// File: rtl/move_arbiter.sv
// Turn arbiter for two player front ends: grants turns, validates moves against the
// board it owns, commits stones/passes, and flags end of game after two consecutive passes.
module move_arbiter #(
    parameter int unsigned BOARD_N    = 9,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                                    clk_in,
    input  logic                                    reset,
    input  logic                                    black_move_ready,
    input  logic [7:0]                              black_move_in,
    input  logic                                    black_pass,
    input  logic                                    white_move_ready,
    input  logic [7:0]                              white_move_in,
    input  logic                                    white_pass,
    output logic [BOARD_N-1:0][BOARD_N-1:0][1:0]    board,
    output logic                                    black_turn,
    output logic                                    white_turn,
    output logic [7:0]                              last_move,
    output logic                                    illegal_move,
    output logic [7:0]                              move_count,
    output logic                                    game_over
);

    localparam int unsigned IW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_COMMIT, ST_REJECT, ST_GAP, ST_OVER
    } state_e;

    typedef enum logic { PL_BLACK = 1'b0, PL_WHITE = 1'b1 } player_e;

    state_e                                 state_q, state_d;
    player_e                                player_q, player_d;
    logic [BOARD_N-1:0][BOARD_N-1:0][1:0]   board_q, board_d;
    logic [7:0]                             mv_q, mv_d;
    logic                                   pass_q, pass_d;
    logic [1:0]                             pass_cnt_q, pass_cnt_d;
    logic [GW-1:0]                          gap_q, gap_d;
    logic                                   black_turn_q, black_turn_d;
    logic                                   white_turn_q, white_turn_d;
    logic [7:0]                             last_q, last_d;
    logic                                   illegal_q, illegal_d;
    logic [7:0]                             count_q, count_d;
    logic                                   over_q, over_d;

    logic [3:0]    mv_row_c, mv_col_c;
    logic          in_range_c;
    logic [1:0]    cell_c;

    // Out-of-range coordinates never reach the array index.
    always_comb begin
        mv_row_c   = mv_q[7:4];
        mv_col_c   = mv_q[3:0];
        in_range_c = (32'(mv_row_c) < BOARD_N) && (32'(mv_col_c) < BOARD_N);
        cell_c     = 2'b00;
        if (in_range_c) begin
            cell_c = board_q[IW'(mv_row_c)][IW'(mv_col_c)];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            player_q     <= PL_BLACK;
            board_q      <= '0;
            mv_q         <= 8'h00;
            pass_q       <= 1'b0;
            pass_cnt_q   <= 2'd0;
            gap_q        <= '0;
            black_turn_q <= 1'b1;
            white_turn_q <= 1'b0;
            last_q       <= 8'h00;
            illegal_q    <= 1'b0;
            count_q      <= 8'h00;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            player_q     <= player_d;
            board_q      <= board_d;
            mv_q         <= mv_d;
            pass_q       <= pass_d;
            pass_cnt_q   <= pass_cnt_d;
            gap_q        <= gap_d;
            black_turn_q <= black_turn_d;
            white_turn_q <= white_turn_d;
            last_q       <= last_d;
            illegal_q    <= illegal_d;
            count_q      <= count_d;
            over_q       <= over_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        player_d     = player_q;
        board_d      = board_q;
        mv_d         = mv_q;
        pass_d       = pass_q;
        pass_cnt_d   = pass_cnt_q;
        gap_d        = gap_q;
        black_turn_d = black_turn_q;
        white_turn_d = white_turn_q;
        last_d       = last_q;
        illegal_d    = 1'b0;
        count_d      = count_q;
        over_d       = over_q;

        unique case (state_q)
            ST_IDLE: begin
                // Only the player holding the turn is heard.
                if (player_q == PL_BLACK && black_move_ready) begin
                    mv_d         = black_move_in;
                    pass_d       = black_pass;
                    black_turn_d = 1'b0;
                    white_turn_d = 1'b0;
                    state_d      = ST_CHECK;
                end else if (player_q == PL_WHITE && white_move_ready) begin
                    mv_d         = white_move_in;
                    pass_d       = white_pass;
                    black_turn_d = 1'b0;
                    white_turn_d = 1'b0;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pass_q || (in_range_c && cell_c == 2'b00)) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_REJECT;
                end
            end
            ST_COMMIT: begin
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                player_d = (player_q == PL_BLACK) ? PL_WHITE : PL_BLACK;
                gap_d    = '0;
                state_d  = ST_GAP;
                if (pass_q) begin
                    last_d     = 8'hFF;
                    pass_cnt_d = pass_cnt_q + 2'd1;
                    if (pass_cnt_q == 2'd1) begin
                        over_d  = 1'b1;
                        state_d = ST_OVER;
                    end
                end else begin
                    board_d[IW'(mv_row_c)][IW'(mv_col_c)] =
                        (player_q == PL_BLACK) ? 2'b01 : 2'b10;
                    last_d     = mv_q;
                    pass_cnt_d = 2'd0;
                end
            end
            ST_REJECT: begin
                illegal_d = 1'b1;
                gap_d     = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    black_turn_d = (player_q == PL_BLACK);
                    white_turn_d = (player_q == PL_WHITE);
                    state_d      = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_OVER: begin
                black_turn_d = 1'b0;
                white_turn_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign board        = board_q;
    assign black_turn   = black_turn_q;
    assign white_turn   = white_turn_q;
    assign last_move    = last_q;
    assign illegal_move = illegal_q;
    assign move_count   = count_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: turn grants, legality, passes, end of game and reset.
module tb_move_arbiter;

    localparam int unsigned N = 9;
    localparam int unsigned G = 4;

    logic                       clk_in = 1'b0;
    logic                       reset;
    logic                       black_move_ready, black_pass, white_move_ready, white_pass;
    logic [7:0]                 black_move_in, white_move_in;
    logic [N-1:0][N-1:0][1:0]   board;
    logic                       black_turn, white_turn, illegal_move, game_over;
    logic [7:0]                 last_move, move_count;

    int n_assert = 0;
    int n_fail   = 0;

    move_arbiter #(.BOARD_N(N), .GAP_CYCLES(G)) dut (
        .clk_in(clk_in), .reset(reset),
        .black_move_ready(black_move_ready), .black_move_in(black_move_in), .black_pass(black_pass),
        .white_move_ready(white_move_ready), .white_move_in(white_move_in), .white_pass(white_pass),
        .board(board), .black_turn(black_turn), .white_turn(white_turn), .last_move(last_move),
        .illegal_move(illegal_move), .move_count(move_count), .game_over(game_over)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Drive strobes for one cycle; returns #1 after the sampling edge (cycle t+1).
    task automatic strobe(input logic b, input logic [7:0] bm, input logic bp,
                          input logic w, input logic [7:0] wm, input logic wp);
        black_move_ready = b; black_move_in = bm; black_pass = bp;
        white_move_ready = w; white_move_in = wm; white_pass = wp;
        tick(1);
        black_move_ready = 1'b0; black_pass = 1'b0;
        white_move_ready = 1'b0; white_pass = 1'b0;
    endtask

    task automatic turns(input string tag, input logic b, input logic w);
        chk({tag, "_black_turn"}, 256'(black_turn), 256'(b));
        chk({tag, "_white_turn"}, 256'(white_turn), 256'(w));
    endtask

    initial begin
        reset = 1'b1;
        black_move_ready = 1'b0; black_move_in = 8'h00; black_pass = 1'b0;
        white_move_ready = 1'b0; white_move_in = 8'h00; white_pass = 1'b0;
        tick(2);
        reset = 1'b0;

        chk("rst_board", 256'(board), 256'(0));
        turns("rst", 1'b1, 1'b0);
        chk("rst_last", 256'(last_move), 256'(8'h00));
        chk("rst_illegal", 256'(illegal_move), 256'(0));
        chk("rst_count", 256'(move_count), 256'(0));
        chk("rst_over", 256'(game_over), 256'(0));

        // 1: black stone at 4,4
        strobe(1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0);
        turns("t1_t1", 1'b0, 1'b0);
        tick(1);
        chk("t1_board_t2", 256'(board[4][4]), 256'(2'b00));
        tick(1);
        chk("t1_board_t3", 256'(board[4][4]), 256'(2'b01));
        chk("t1_count", 256'(move_count), 256'(1));
        chk("t1_last", 256'(last_move), 256'(8'h44));
        tick(G - 1);
        turns("t1_gap_end", 1'b0, 1'b0);
        tick(1);
        turns("t1_grant", 1'b0, 1'b1);

        // 2: white on occupied cell
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0);
        tick(2);
        chk("t2_illegal", 256'(illegal_move), 256'(1));
        chk("t2_board", 256'(board[4][4]), 256'(2'b01));
        chk("t2_count", 256'(move_count), 256'(1));
        tick(1);
        chk("t2_illegal_pulse", 256'(illegal_move), 256'(0));
        tick(G - 1);
        turns("t2_regrant", 1'b0, 1'b1);

        // white plays 1,2 to hand the turn back
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b0);
        tick(2);
        chk("w12_board", 256'(board[1][2]), 256'(2'b10));
        chk("w12_count", 256'(move_count), 256'(2));
        tick(G);
        turns("w12_grant", 1'b1, 1'b0);

        // 3: out-of-range row, then column
        strobe(1'b1, 8'h90, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(2);
        chk("t3_row_illegal", 256'(illegal_move), 256'(1));
        tick(G);
        turns("t3_row_regrant", 1'b1, 1'b0);
        strobe(1'b1, 8'h09, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(2);
        chk("t3_col_illegal", 256'(illegal_move), 256'(1));
        chk("t3_count", 256'(move_count), 256'(2));
        tick(G);
        turns("t3_col_regrant", 1'b1, 1'b0);

        // 5: pass, stone, pass does not end the game
        strobe(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick(2);
        chk("t5_last_pass", 256'(last_move), 256'(8'hFF));
        chk("t5_count1", 256'(move_count), 256'(3));
        tick(G);
        turns("t5_grant_w", 1'b0, 1'b1);
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick(2);
        chk("t5_board00", 256'(board[0][0]), 256'(2'b10));
        chk("t5_last_00", 256'(last_move), 256'(8'h00));
        tick(G);
        strobe(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick(2);
        chk("t5_over", 256'(game_over), 256'(0));
        chk("t5_count3", 256'(move_count), 256'(5));
        tick(G);
        turns("t5_grant_w2", 1'b0, 1'b1);

        // white plays the far corner 8,8
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h88, 1'b0);
        tick(2);
        chk("w88_board", 256'(board[8][8]), 256'(2'b10));
        chk("w88_count", 256'(move_count), 256'(6));
        tick(G);
        turns("w88_grant", 1'b1, 1'b0);

        // 6: simultaneous strobes on black's turn; white strobe in GAP
        strobe(1'b1, 8'h33, 1'b0, 1'b1, 8'h34, 1'b0);
        tick(2);
        chk("t6_board33", 256'(board[3][3]), 256'(2'b01));
        chk("t6_board34", 256'(board[3][4]), 256'(2'b00));
        chk("t6_count", 256'(move_count), 256'(7));
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0);
        tick(G - 1);
        turns("t6_grant", 1'b0, 1'b1);
        tick(3);
        chk("t6_gap_drop_board", 256'(board[5][5]), 256'(2'b00));
        chk("t6_gap_drop_count", 256'(move_count), 256'(7));
        turns("t6_still_idle", 1'b0, 1'b1);

        // reset while the move sits in CHECK
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_board", 256'(board), 256'(0));
        turns("t6_rst", 1'b1, 1'b0);
        chk("t6_rst_count", 256'(move_count), 256'(0));
        tick(4);
        chk("t6_rst_no_write", 256'(board), 256'(0));

        // 4: two passes end the game
        strobe(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        tick(2 + G);
        turns("t4_grant_w", 1'b0, 1'b1);
        strobe(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        tick(1);
        chk("t4_over_t2", 256'(game_over), 256'(0));
        tick(1);
        chk("t4_over", 256'(game_over), 256'(1));
        chk("t4_last", 256'(last_move), 256'(8'hFF));
        chk("t4_count", 256'(move_count), 256'(2));
        turns("t4_over", 1'b0, 1'b0);
        strobe(1'b1, 8'h22, 1'b0, 1'b1, 8'h23, 1'b0);
        tick(G + 4);
        chk("t4_ignored_board", 256'(board), 256'(0));
        chk("t4_ignored_count", 256'(move_count), 256'(2));
        chk("t4_sticky", 256'(game_over), 256'(1));
        turns("t4_ignored", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
